// File: rtl/wb_regfile.sv
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : Write-back stage register file with load/compare formatting,
//             same-cycle read bypass and a retire counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wb_regfile #(
    parameter int RETIRE_W = 32
) (
    input  wire logic                CLK,
    input  wire logic                Reset,
    input  wire logic                RegWr,
    input  wire logic [1:0]          RegDst,
    input  wire logic [1:0]          Digit,
    input  wire logic                immres,
    input  wire logic [1:0]          cmp,
    input  wire logic [4:0]          WriteReg,
    input  wire logic [31:0]         AluOutput,
    input  wire logic [31:0]         MemData,
    input  wire logic [31:0]         PC,
    input  wire logic [31:0]         extend,
    input  wire logic [4:0]          ReadReg1,
    input  wire logic [4:0]          ReadReg2,
    output logic      [31:0]         ReadData1,
    output logic      [31:0]         ReadData2,
    output logic      [31:0]         WriteData,
    output logic      [RETIRE_W-1:0] RetireCount
);

    localparam logic [1:0] c_DST_ALU = 2'b00;
    localparam logic [1:0] c_DST_MEM = 2'b01;
    localparam logic [1:0] c_DST_PC  = 2'b10;

    logic [31:0]         r_regs [1:31];
    logic [RETIRE_W-1:0] r_retire;

    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_load;
    logic [31:0] w_cmp;
    logic [31:0] w_wdata;
    logic        w_wr_en;

    // Little-endian lane selection; unused low offset bits fall away naturally.
    always_comb begin
        w_half = AluOutput[1] ? MemData[31:16] : MemData[15:0];
        case (AluOutput[1:0])
            2'd0:    w_byte = MemData[7:0];
            2'd1:    w_byte = MemData[15:8];
            2'd2:    w_byte = MemData[23:16];
            default: w_byte = MemData[31:24];
        endcase
        case (Digit)
            2'b00:   w_load = MemData;
            2'b01:   w_load = {{16{w_half[15]}}, w_half};
            2'b10:   w_load = {{24{w_byte[7]}}, w_byte};
            default: w_load = {24'd0, w_byte};
        endcase
    end

    always_comb begin
        case (cmp)
            2'b00:   w_cmp = {31'd0, AluOutput[31]};
            2'b01:   w_cmp = {31'd0, (AluOutput == 32'd0)};
            2'b10:   w_cmp = {31'd0, (AluOutput != 32'd0)};
            default: w_cmp = 32'd0;
        endcase
    end

    always_comb begin
        if (immres) begin
            w_wdata = extend;
        end else begin
            case (RegDst)
                c_DST_ALU: w_wdata = AluOutput;
                c_DST_MEM: w_wdata = w_load;
                c_DST_PC:  w_wdata = PC + 32'd4;
                default:   w_wdata = w_cmp;
            endcase
        end
    end

    assign w_wr_en   = RegWr && (WriteReg != 5'd0);
    assign WriteData = w_wdata;

    // Bypass takes precedence so a write is visible in the same cycle.
    always_comb begin
        if (ReadReg1 == 5'd0)
            ReadData1 = 32'd0;
        else if (w_wr_en && (WriteReg == ReadReg1))
            ReadData1 = w_wdata;
        else
            ReadData1 = r_regs[ReadReg1];

        if (ReadReg2 == 5'd0)
            ReadData2 = 32'd0;
        else if (w_wr_en && (WriteReg == ReadReg2))
            ReadData2 = w_wdata;
        else
            ReadData2 = r_regs[ReadReg2];
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_retire <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[WriteReg] <= w_wdata;
            end
            if (RegWr) begin
                r_retire <= r_retire + 1'b1;
            end
        end
    end

    assign RetireCount = r_retire;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Directed plus randomized checks of wb_regfile against a
//             behavioural model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        Reset, RegWr, immres;
    logic [1:0]  RegDst, Digit, cmp;
    logic [4:0]  WriteReg, ReadReg1, ReadReg2;
    logic [31:0] AluOutput, MemData, PC, extend;
    logic [31:0] rd1, rd2, wd, rc;
    logic [31:0] rd1_b, rd2_b, wd_b;
    logic [3:0]  rc4;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    longint unsigned m_ret;

    always #5 clk = ~clk;

    wb_regfile #(.RETIRE_W(32)) dut (
        .CLK(clk), .Reset(Reset), .RegWr(RegWr), .RegDst(RegDst), .Digit(Digit),
        .immres(immres), .cmp(cmp), .WriteReg(WriteReg), .AluOutput(AluOutput),
        .MemData(MemData), .PC(PC), .extend(extend), .ReadReg1(ReadReg1),
        .ReadReg2(ReadReg2), .ReadData1(rd1), .ReadData2(rd2), .WriteData(wd),
        .RetireCount(rc)
    );

    wb_regfile #(.RETIRE_W(4)) dut4 (
        .CLK(clk), .Reset(Reset), .RegWr(RegWr), .RegDst(RegDst), .Digit(Digit),
        .immres(immres), .cmp(cmp), .WriteReg(WriteReg), .AluOutput(AluOutput),
        .MemData(MemData), .PC(PC), .extend(extend), .ReadReg1(ReadReg1),
        .ReadReg2(ReadReg2), .ReadData1(rd1_b), .ReadData2(rd2_b), .WriteData(wd_b),
        .RetireCount(rc4)
    );

    function automatic logic [31:0] sext(input longint unsigned v, input int bits);
        longint unsigned r;
        r = v;
        if (v >= (64'd1 << (bits - 1))) r = v + (64'd1 << 32) - (64'd1 << bits);
        return r[31:0];
    endfunction

    function automatic logic [31:0] exp_wd();
        longint unsigned mem, off, piece;
        logic [31:0] r;
        mem = MemData;
        off = AluOutput % 4;
        if (immres) return extend;
        case (RegDst)
            2'd0: r = AluOutput;
            2'd1: begin
                if (Digit == 2'd0) r = MemData;
                else if (Digit == 2'd1) begin
                    piece = (mem >> (16 * (off / 2))) % 65536;
                    r = sext(piece, 16);
                end else begin
                    piece = (mem >> (8 * off)) % 256;
                    r = (Digit == 2'd2) ? sext(piece, 8) : piece[31:0];
                end
            end
            2'd2: begin
                piece = (64'(PC) + 4) % (64'd1 << 32);
                r = piece[31:0];
            end
            default: begin
                if (cmp == 2'd0) r = (AluOutput >= 32'h8000_0000) ? 32'd1 : 32'd0;
                else if (cmp == 2'd1) r = (AluOutput == 0) ? 32'd1 : 32'd0;
                else if (cmp == 2'd2) r = (AluOutput != 0) ? 32'd1 : 32'd0;
                else r = 32'd0;
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (RegWr && WriteReg != 0 && WriteReg == idx) return exp_wd();
        return m_regs[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all();
        check("WriteData", wd, exp_wd());
        check("ReadData1", rd1, exp_rd(ReadReg1));
        check("ReadData2", rd2, exp_rd(ReadReg2));
        check("RetireCount", rc, 32'(m_ret % (64'd1 << 32)));
        check("RetireCount4", {28'd0, rc4}, 32'(m_ret % 16));
    endtask

    // Settle, compare, then clock one edge and advance the model.
    task automatic cycle(input bit do_check);
        logic [31:0] w;
        #1;
        if (do_check) check_all();
        w = exp_wd();
        @(posedge clk);
        if (Reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_ret = 0;
        end else if (RegWr) begin
            m_ret++;
            if (WriteReg != 0) m_regs[WriteReg] = w;
        end
        #1;
    endtask

    task automatic idle();
        Reset = 0; RegWr = 0; RegDst = 0; Digit = 0; immres = 0; cmp = 0;
        WriteReg = 0; AluOutput = 0; MemData = 0; PC = 0; extend = 0;
    endtask

    initial begin
        idle();
        ReadReg1 = 0; ReadReg2 = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_ret = 0;
        @(negedge clk);

        Reset = 1;
        cycle(0);
        Reset = 0; ReadReg1 = 5; ReadReg2 = 31;
        #1;
        check("rst_rd1", rd1, 32'd0);
        check("rst_rd2", rd2, 32'd0);
        check("rst_rc", rc, 32'd0);

        RegWr = 1; RegDst = 0; AluOutput = 32'hDEADBEEF; WriteReg = 7; ReadReg1 = 7;
        #1;
        check("bypass_rd1", rd1, 32'hDEADBEEF);
        cycle(1);
        RegWr = 0;
        #1;
        check("stored_rd1", rd1, 32'hDEADBEEF);
        check("rc_after_one", rc, 32'd1);

        RegDst = 1; MemData = 32'h80FF7F01; AluOutput = 32'h1; Digit = 2'b10;
        #1;
        check("lb_off1", wd, 32'h0000007F);
        check("model_lb_off1", exp_wd(), 32'h0000007F);
        Digit = 2'b11; AluOutput = 32'h2;
        #1;
        check("lbu_off2", wd, 32'h000000FF);
        Digit = 2'b01;
        #1;
        check("lh_off2", wd, 32'hFFFF80FF);
        check("model_lh_off2", exp_wd(), 32'hFFFF80FF);
        cycle(1);

        RegWr = 1; RegDst = 0; WriteReg = 0; AluOutput = 32'h12345678; ReadReg1 = 0;
        #1;
        check("x0_before", rd1, 32'd0);
        cycle(1);
        RegWr = 0;
        #1;
        check("x0_after", rd1, 32'd0);
        check("rc_x0_write", rc, 32'd2);

        RegDst = 2; PC = 32'hFFFFFFFC;
        #1; check("pc_wrap", wd, 32'h0);
        RegDst = 3; cmp = 0; AluOutput = 32'h80000000;
        #1; check("cmp_neg", wd, 32'h1);
        cmp = 1; AluOutput = 0;
        #1; check("cmp_zero", wd, 32'h1);
        check("model_cmp_zero", exp_wd(), 32'h1);
        immres = 1; extend = 32'hFFFF8000;
        for (int d = 0; d < 4; d++) begin
            RegDst = 2'(d);
            #1; check("immres", wd, 32'hFFFF8000);
        end
        cycle(1);

        idle();
        Reset = 1; RegWr = 1; WriteReg = 3; AluOutput = 32'h55;
        cycle(1);
        Reset = 0; RegWr = 0; ReadReg1 = 3;
        #1;
        check("rst_prio_x3", rd1, 32'd0);
        check("rst_prio_rc", rc, 32'd0);
        RegWr = 1; WriteReg = 9;
        for (int i = 0; i < 16; i++) cycle(1);
        RegWr = 0;
        #1;
        check("rc4_wrap", {28'd0, rc4}, 32'd0);
        check("rc_16", rc, 32'd16);

        for (int i = 0; i < 3000; i++) begin
            Reset     = ($urandom_range(0, 59) == 0);
            RegWr     = ($urandom_range(0, 3) != 0);
            RegDst    = 2'($urandom);
            Digit     = 2'($urandom);
            immres    = ($urandom_range(0, 7) == 0);
            cmp       = 2'($urandom);
            WriteReg  = 5'($urandom);
            AluOutput = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            MemData   = $urandom;
            PC        = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
            extend    = $urandom;
            ReadReg1  = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom);
            ReadReg2  = ($urandom_range(0, 3) == 0) ? ReadReg1 : 5'($urandom);
            cycle(1);
            if (ReadReg1 == ReadReg2) check("same_index", rd1, rd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have exactly one parameter: RETIRE_W, default 32, the width of the retire counter.
REQ-002 The block SHALL have exactly the following ports, in this order:
- CLK  in  1  clock; all state updates on the rising edge
- Reset  in  1  reset; synchronous, active-high
- RegWr  in  1  write-back enable
- RegDst  in  2  write-data source select
- Digit  in  2  load width/sign select
- immres  in  1  write the extended immediate directly
- cmp  in  2  compare-result format select
- WriteReg  in  5  destination register index
- AluOutput  in  32  ALU result; bits [1:0] also give the load byte offset
- MemData  in  32  raw 32-bit word read from data memory
- PC  in  32  PC of the instruction being written back
- extend  in  32  extended immediate
- ReadReg1  in  5  read port 1 index
- ReadReg2  in  5  read port 2 index
- ReadData1  out  32  read port 1 data
- ReadData2  out  32  read port 2 data
- WriteData  out  32  selected write-back value
- RetireCount  out  RETIRE_W  count of cycles with RegWr=1

Function
REQ-003 WriteData SHALL be combinational and selected in this order:
- immres=1 -> extend.
- Otherwise RegDst=00 -> AluOutput.
- RegDst=01 -> load-formatted MemData.
- RegDst=10 -> PC+4, modulo 2^32.
- RegDst=11 -> compare-formatted value.
REQ-004 Load formatting SHALL be little-endian, with offset = AluOutput[1:0]:
- Digit=00 -> the whole MemData word.
- Digit=01 -> halfword MemData[16*off[1]+:16], sign-extended.
- Digit=10 -> byte MemData[8*off+:8], sign-extended.
- Digit=11 -> that byte, zero-extended.
REQ-005 For Digit=00 or Digit=01, misaligned offset bits (off[1:0] for word, off[0] for half) SHALL be ignored.
REQ-006 Compare formatting SHALL be:
- cmp=00 -> {31'b0, AluOutput[31]}.
- cmp=01 -> {31'b0, AluOutput==0}.
- cmp=10 -> {31'b0, AluOutput!=0}.
- cmp=11 -> 32'b0.
REQ-007 The block SHALL hold 31 32-bit registers, x1 to x31; x0 SHALL always read 0 and SHALL never be stored.
REQ-008 On a rising edge with Reset=0, RegWr=1 and WriteReg!=0, register[WriteReg] SHALL take WriteData.
REQ-009 When RegWr=0 or WriteReg=0, no register SHALL change.
REQ-010 ReadDataN SHALL be combinational: 0 if ReadRegN=0, otherwise register[ReadRegN].
REQ-011 Bypass: if RegWr=1, WriteReg!=0 and WriteReg==ReadRegN, then ReadDataN SHALL equal the current WriteData, so a same-cycle write is visible with zero latency.
REQ-012 Both read ports SHALL operate independently; identical indices on both ports SHALL return identical data.
REQ-013 RetireCount SHALL increment by 1 on each rising edge with Reset=0 and RegWr=1, including writes to x0.
REQ-014 RetireCount SHALL wrap from 2^RETIRE_W-1 to 0 with no flag.
REQ-015 Inputs SHALL be consumed as presented in the same cycle; the block SHALL add no pipeline stage and SHALL have no handshake or stall.

Reset
REQ-016 A rising edge with Reset=1 SHALL clear x1 to x31 to 0 and RetireCount to 0.
REQ-017 Reset SHALL take priority over a simultaneous write: with Reset=1 and RegWr=1, no register SHALL be written and RetireCount SHALL stay 0.
REQ-018 During reset, ReadDataN and WriteData SHALL remain combinational per REQ-003 to REQ-011, including bypass; after the first reset edge, non-bypassed reads SHALL return 0.
REQ-019 Reset asserted mid-sequence SHALL discard all prior register contents with no partial state retained.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset 1 cycle, then ReadReg1=5, ReadReg2=31 -> ReadData1=0, ReadData2=0, RetireCount=0.
- RegWr=1, RegDst=00, AluOutput=0xDEADBEEF, WriteReg=7, ReadReg1=7 in the same cycle -> ReadData1=0xDEADBEEF before the edge (bypass); after the edge with RegWr=0 -> still 0xDEADBEEF; RetireCount=1.
- RegDst=01, MemData=0x80FF7F01, AluOutput=...01:
  - Digit=10 -> WriteData=0x0000007F.
  - Digit=11 with AluOutput=...02 -> 0x000000FF.
  - Digit=01 with AluOutput=...02 -> 0xFFFF80FF.
- RegWr=1, WriteReg=0, AluOutput=0x12345678, ReadReg1=0 -> ReadData1=0 both before and after the edge; RetireCount still increments.
- RegDst=10, PC=0xFFFFFFFC -> WriteData=0x00000000; RegDst=11, cmp=00, AluOutput=0x80000000 -> 1; cmp=01, AluOutput=0 -> 1; immres=1, extend=0xFFFF8000 -> 0xFFFF8000 regardless of RegDst.
- Write x3=0x55 with RegWr=1 and Reset=1 on the same edge -> x3 reads 0 and RetireCount=0; with RETIRE_W=4, 16 writes from reset -> RetireCount=0.
